key_command_encoder: RTL

//  Command initiator for the game datapath: turns the raw, bouncing, active-low push-buttons into clean one-cycle commands.
//  Its outputs drive the datapath's ldFM / ldSM / dir inputs in the top level, replacing direct ~KEY wiring.
//  Per key: 2-FF synchroniser, debounce counter, press-edge detector; direction keys add hold-to-auto-repeat.

---
 rtl/key_command_encoder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/key_command_encoder.sv
// rtl/key_command_encoder.sv - debounced one-cycle key commands with direction auto-repeat
module key_command_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] key_n,
  input  logic       en,
  output logic       ldFM,
  output logic       ldSM,
  output logic [1:0] dir,
  output logic [3:0] key_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       level;
  logic [3:0]       accepted;
  logic [3:0]       press;
  logic [CNT_W-1:0] db_cnt [4];

  rep_state_t       rep_state_q [2];
  rep_state_t       rep_state_d [2];
  logic [CNT_W-1:0] rep_cnt_q [2];
  logic [CNT_W-1:0] rep_cnt_d [2];
  logic [1:0]       dir_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // 1 = pressed from here on
  assign level = ~sync2;

  // Any cycle matching the accepted level throws away the whole count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      accepted <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (level[i] == accepted[i]) begin
          db_cnt[i] <= CNT_ZERO;
        end else if (db_cnt[i] == DB_LAST) begin
          accepted[i] <= ~accepted[i];
          db_cnt[i]   <= CNT_ZERO;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // key_state doubles as the previous accepted level for edge detection
  assign press = accepted & ~key_state;

  always_comb begin
    dir_d = 2'b00;
    for (int i = 0; i < 2; i++) begin
      rep_state_d[i] = rep_state_q[i];
      rep_cnt_d[i]   = rep_cnt_q[i];
      if (!en) begin
        rep_state_d[i] = IDLE;
        rep_cnt_d[i]   = CNT_ZERO;
      end else begin
        case (rep_state_q[i])
          IDLE: begin
            if (press[i]) begin
              rep_state_d[i] = DELAY;
              rep_cnt_d[i]   = CNT_ZERO;
              dir_d[i]       = 1'b1;
            end
          end
          DELAY: begin
            if (!accepted[i]) begin
              rep_state_d[i] = IDLE;
              rep_cnt_d[i]   = CNT_ZERO;
            end else if (rep_cnt_q[i] == RD_LAST) begin
              rep_state_d[i] = REPEAT;
              rep_cnt_d[i]   = CNT_ZERO;
              dir_d[i]       = 1'b1;
            end else begin
              rep_cnt_d[i] = rep_cnt_q[i] + CNT_ONE;
            end
          end
          REPEAT: begin
            if (!accepted[i]) begin
              rep_state_d[i] = IDLE;
              rep_cnt_d[i]   = CNT_ZERO;
            end else if (rep_cnt_q[i] == RP_LAST) begin
              rep_cnt_d[i] = CNT_ZERO;
              dir_d[i]     = 1'b1;
            end else begin
              rep_cnt_d[i] = rep_cnt_q[i] + CNT_ONE;
            end
          end
          default: begin
            rep_state_d[i] = IDLE;
            rep_cnt_d[i]   = CNT_ZERO;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        rep_state_q[i] <= IDLE;
        rep_cnt_q[i]   <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        rep_state_q[i] <= rep_state_d[i];
        rep_cnt_q[i]   <= rep_cnt_d[i];
      end
    end
  end

  // A flag press swallows a simultaneous step press.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ldFM      <= 1'b0;
      ldSM      <= 1'b0;
      dir       <= 2'b00;
      key_state <= 4'h0;
    end else begin
      ldFM      <= en & press[3];
      ldSM      <= en & press[2] & ~press[3];
      dir       <= dir_d;
      key_state <= accepted;
    end
  end

endmodule
